// File: rtl/avalon_s_pkg.sv
// ---------------------------------------------------------------------------
// avalon_s_pkg
// Shared types and constants for the Avalon standard crossbar and its
// per-device-port registered bridges.
//   bridge_state_t   : bridge FSM states (IDLE -> BUSY -> DONE -> IDLE)
//   ERR_DATA_DEFAULT : readdata returned to the host when a device read times out
// ---------------------------------------------------------------------------
package avalon_s_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } bridge_state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/avalon_s_device_bridge.sv
// ---------------------------------------------------------------------------
// avalon_s_device_bridge
// Registered Avalon standard bridge between one crossbar device port and a
// slow or remote device. Command, readdata and waitrequest are all registered,
// and a watchdog ends any device transfer that stalls for TIMEOUT cycles.
//
// Ports:
//   clk, rst                : clock, asynchronous active-low reset
//   host_avn_*              : slave side, driven by the crossbar device port
//   device_avn_*            : master side, registered command to the device
//   timeout_err             : sticky flag, a device transfer timed out
//   timeout_clr             : synchronous clear of timeout_err (set wins)
// ---------------------------------------------------------------------------
module avalon_s_device_bridge
  import avalon_s_pkg::*;
#(
  parameter int            DW       = 32,
  parameter int            AW       = 32,
  parameter int            TIMEOUT  = 256,
  parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  // host (crossbar) side
  input  logic            host_avn_read,
  input  logic            host_avn_write,
  input  logic [AW-1:0]   host_avn_address,
  input  logic [DW/8-1:0] host_avn_byte_enable,
  input  logic [DW-1:0]   host_avn_writedata,
  output logic [DW-1:0]   host_avn_readdata,
  output logic            host_avn_waitrequest,
  // device side
  output logic            device_avn_read,
  output logic            device_avn_write,
  output logic [AW-1:0]   device_avn_address,
  output logic [DW/8-1:0] device_avn_byte_enable,
  output logic [DW-1:0]   device_avn_writedata,
  input  logic [DW-1:0]   device_avn_readdata,
  input  logic            device_avn_waitrequest,
  // watchdog status
  output logic            timeout_err,
  input  logic            timeout_clr
);

  // A zero TIMEOUT still needs a legal one-bit counter even though it never fires.
  localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  bridge_state_t   state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dev_read_q, dev_read_d;
  logic            dev_write_q, dev_write_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW/8-1:0] be_q, be_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;

  logic host_req;
  logic dev_done;
  logic wd_fire;

  assign host_req = host_avn_read | host_avn_write;
  assign dev_done = ~device_avn_waitrequest;
  assign wd_fire  = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // ---- state register ------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ---- next-state logic ----------------------------------------------------
  // NOTE: each combinational output gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (host_req) state_d = BUSY;
      // Device completion is tested first, so it beats a same-cycle timeout.
      BUSY:    if (dev_done || wd_fire) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- output decode -------------------------------------------------------
  // Pure state decode: the host stall has no combinational input path.
  always_comb begin
    host_avn_waitrequest = 1'b1;
    if (state_q == DONE) host_avn_waitrequest = 1'b0;
  end

  // ---- datapath next values ------------------------------------------------
  always_comb begin
    cnt_d       = cnt_q;
    dev_read_d  = dev_read_q;
    dev_write_d = dev_write_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = timeout_clr ? 1'b0 : err_q;

    case (state_q)
      IDLE: begin
        if (host_req) begin
          // Read and write together is treated as a read.
          dev_read_d  = host_avn_read;
          dev_write_d = host_avn_write & ~host_avn_read;
          addr_d      = host_avn_address;
          be_d        = host_avn_byte_enable;
          wdata_d     = host_avn_writedata;
          cnt_d       = '0;
        end
      end
      BUSY: begin
        if (dev_done) begin
          if (dev_read_q) rdata_d = device_avn_readdata;
          dev_read_d  = 1'b0;
          dev_write_d = 1'b0;
        end else if (wd_fire) begin
          if (dev_read_q) rdata_d = ERR_DATA;
          dev_read_d  = 1'b0;
          dev_write_d = 1'b0;
          err_d       = 1'b1;  // overrides a same-cycle clear
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  // ---- datapath registers --------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      dev_read_q  <= 1'b0;
      dev_write_q <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      dev_read_q  <= dev_read_d;
      dev_write_q <= dev_write_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign device_avn_read        = dev_read_q;
  assign device_avn_write       = dev_write_q;
  assign device_avn_address     = addr_q;
  assign device_avn_byte_enable = be_q;
  assign device_avn_writedata   = wdata_q;
  assign host_avn_readdata      = rdata_q;
  assign timeout_err            = err_q;

endmodule

// File: tb/tb_avalon_s_device_bridge.sv
// ---------------------------------------------------------------------------
// tb_avalon_s_device_bridge
// Directed and randomized transfers through the bridge with TIMEOUT=8. The
// expected timeline of each transfer is computed from the number of device
// wait cycles: BUSY lasts w+1 cycles if the device answers within the
// watchdog window, otherwise TIMEOUT cycles ending in an error response.
// ---------------------------------------------------------------------------
module tb_avalon_s_device_bridge;

  localparam int          DW  = 32;
  localparam int          AW  = 32;
  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic            clk;
  logic            rst;
  logic            host_avn_read;
  logic            host_avn_write;
  logic [AW-1:0]   host_avn_address;
  logic [DW/8-1:0] host_avn_byte_enable;
  logic [DW-1:0]   host_avn_writedata;
  logic [DW-1:0]   host_avn_readdata;
  logic            host_avn_waitrequest;
  logic            device_avn_read;
  logic            device_avn_write;
  logic [AW-1:0]   device_avn_address;
  logic [DW/8-1:0] device_avn_byte_enable;
  logic [DW-1:0]   device_avn_writedata;
  logic [DW-1:0]   device_avn_readdata;
  logic            device_avn_waitrequest;
  logic            timeout_err;
  logic            timeout_clr;

  avalon_s_device_bridge #(
    .DW(DW), .AW(AW), .TIMEOUT(TO), .ERR_DATA(ERR)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .host_avn_read          (host_avn_read),
    .host_avn_write         (host_avn_write),
    .host_avn_address       (host_avn_address),
    .host_avn_byte_enable   (host_avn_byte_enable),
    .host_avn_writedata     (host_avn_writedata),
    .host_avn_readdata      (host_avn_readdata),
    .host_avn_waitrequest   (host_avn_waitrequest),
    .device_avn_read        (device_avn_read),
    .device_avn_write       (device_avn_write),
    .device_avn_address     (device_avn_address),
    .device_avn_byte_enable (device_avn_byte_enable),
    .device_avn_writedata   (device_avn_writedata),
    .device_avn_readdata    (device_avn_readdata),
    .device_avn_waitrequest (device_avn_waitrequest),
    .timeout_err            (timeout_err),
    .timeout_clr            (timeout_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] m_rdata;   // host readdata the model expects
  logic        m_err;     // sticky error the model expects

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One host transfer starting in an IDLE cycle. w = device wait cycles
  // before it drops waitrequest; drop = release the host request in DONE;
  // clr = hold timeout_clr high for the whole transfer.
  task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wdata,
                      input logic [31:0] rdata, input int w, input bit drop,
                      input logic clr);
    bit   to;
    int   busy;
    int   done_c;
    logic eff_rd;
    logic eff_wr;
    eff_rd = rd;
    eff_wr = wr & ~rd;
    to     = (w >= TO);
    busy   = to ? TO : w + 1;
    done_c = 2 + busy;

    @(negedge clk);
    check("idle_wait", host_avn_waitrequest, 1);
    check("idle_dev_rw", {device_avn_read, device_avn_write}, 0);
    host_avn_read        = rd;
    host_avn_write       = wr;
    host_avn_address     = addr;
    host_avn_byte_enable = be;
    host_avn_writedata   = wdata;
    timeout_clr          = clr;

    for (int c = 2; c <= done_c; c++) begin
      @(negedge clk);
      check("host_wait", host_avn_waitrequest, (c != done_c));
      if (c < done_c) begin
        check("dev_read", device_avn_read, eff_rd);
        check("dev_write", device_avn_write, eff_wr);
        check("dev_addr", device_avn_address, addr);
        check("dev_be", device_avn_byte_enable, be);
        check("dev_wdata", device_avn_writedata, wdata);
        device_avn_waitrequest = ((c - 2) < w);
        // Junk data while stalled so an early capture is visible.
        device_avn_readdata    = ((c - 2) < w) ? ~rdata : rdata;
      end else begin
        if (eff_rd) m_rdata = to ? ERR : rdata;
        if (to) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        check("done_dev_rw", {device_avn_read, device_avn_write}, 0);
        check("done_rdata", host_avn_readdata, m_rdata);
        check("done_err", timeout_err, m_err);
        if (drop) begin
          host_avn_read  = 1'b0;
          host_avn_write = 1'b0;
        end
        timeout_clr            = 1'b0;
        device_avn_waitrequest = 1'b1;
      end
    end
  endtask

  task automatic clear_err();
    @(negedge clk);
    check("err_sticky", timeout_err, m_err);
    timeout_clr = 1'b1;
    @(negedge clk);
    timeout_clr = 1'b0;
    m_err = 1'b0;
    check("err_cleared", timeout_err, m_err);
  endtask

  initial begin
    logic        r_rd;
    logic        r_wr;
    int          r_w;
    host_avn_read          = 1'b0;
    host_avn_write         = 1'b0;
    host_avn_address       = '0;
    host_avn_byte_enable   = '0;
    host_avn_writedata     = '0;
    device_avn_readdata    = '0;
    device_avn_waitrequest = 1'b1;
    timeout_clr            = 1'b0;
    m_rdata                = '0;
    m_err                  = 1'b0;

    // Reset state
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("rst_wait", host_avn_waitrequest, 1);
    check("rst_dev_rw", {device_avn_read, device_avn_write}, 0);
    check("rst_dev_addr", device_avn_address, 0);
    check("rst_dev_be", device_avn_byte_enable, 0);
    check("rst_dev_wdata", device_avn_writedata, 0);
    check("rst_rdata", host_avn_readdata, 0);
    check("rst_err", timeout_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Zero-wait read
    xfer(1, 0, 32'h100, 4'hF, 32'h0, 32'h12345678, 0, 1, 0);
    // Write with 4 device wait cycles
    xfer(0, 1, 32'h200, 4'b0011, 32'hA5A5A5A5, 32'h0BAD0BAD, 4, 1, 0);
    // Read timeout, then sticky check and clear
    xfer(1, 0, 32'h300, 4'hF, 32'h0, 32'h11112222, 20, 1, 0);
    clear_err();
    // Device answers on the watchdog cycle itself
    xfer(1, 0, 32'h304, 4'hF, 32'h0, 32'hCAFEF00D, TO - 1, 1, 0);
    // Write timeout with clear held high: set wins, readdata untouched
    xfer(0, 1, 32'h308, 4'hC, 32'h77778888, 32'h0, TO + 1, 1, 1);
    clear_err();
    // Back-to-back: read 0x0 then write 0x4 with the request held
    xfer(1, 0, 32'h0, 4'hF, 32'h0, 32'h55AA55AA, 1, 0, 0);
    xfer(0, 1, 32'h4, 4'hF, 32'h13579BDF, 32'h0, 2, 1, 0);
    // Read and write together is a read
    xfer(1, 1, 32'h40, 4'h5, 32'hFFFF0000, 32'h2468ACE0, 1, 1, 0);

    // Randomized transfers
    for (int i = 0; i < 24; i++) begin
      r_rd = 1'($urandom_range(0, 1));
      r_wr = r_rd ? 1'($urandom_range(0, 1)) : 1'b1;
      r_w  = int'($urandom_range(0, TO + 3));
      xfer(r_rd, r_wr, $urandom, 4'($urandom), $urandom, $urandom, r_w,
           bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset in the middle of a stalled read
    @(negedge clk);
    host_avn_read          = 1'b1;
    host_avn_write         = 1'b0;
    host_avn_address       = 32'h500;
    device_avn_waitrequest = 1'b1;
    @(negedge clk);
    check("mid_dev_read", device_avn_read, 1);
    host_avn_read = 1'b0;
    #2 rst = 1'b0;
    #1;
    m_rdata = '0;
    m_err   = 1'b0;
    check("arst_dev_rw", {device_avn_read, device_avn_write}, 0);
    check("arst_wait", host_avn_waitrequest, 1);
    check("arst_rdata", host_avn_readdata, m_rdata);
    check("arst_err", timeout_err, m_err);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_wait", host_avn_waitrequest, 1);
    check("post_rst_dev_rw", {device_avn_read, device_avn_write}, 0);
    xfer(1, 0, 32'h600, 4'hF, 32'h0, 32'h0F0F0F0F, 3, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
